// File: rtl/adc_sample_conditioner.sv
// Conditions MCP3202 samples: edge-qualified capture, offset-binary to signed, optional DC
// removal, 2^AVG_LOG2 box-car average, left-justified 16-bit result on a valid/ready port.
module adc_sample_conditioner #(
   parameter int unsigned AVG_LOG2 = 2,
   parameter int unsigned DC_SHIFT = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [11:0] i_data,
   input  logic        i_dv,
   input  logic        i_dc_bypass,
   input  logic        i_ready,
   input  logic        i_clr_overrun,
   output logic [15:0] o_sample,
   output logic        o_valid,
   output logic        o_overrun
);

   localparam int unsigned DW = 13 + DC_SHIFT;
   localparam int unsigned SW = 13 + AVG_LOG2;
   localparam int unsigned CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam logic [CW-1:0] CntLast = CW'((1 << AVG_LOG2) - 1);

   if (AVG_LOG2 > 6) begin : g_bad_avg
      $error("adc_sample_conditioner: AVG_LOG2 must be 0..6");
   end
   if (DC_SHIFT < 4 || DC_SHIFT > 14) begin : g_bad_dc
      $error("adc_sample_conditioner: DC_SHIFT must be 4..14");
   end

   logic                 dv_q;
   logic                 cap_q;
   logic [11:0]          data_q;
   logic                 s1_q;
   logic signed [12:0]   x_q;
   logic signed [DW-1:0] dc_acc_q;
   logic signed [SW-1:0] sum_q;
   logic [CW-1:0]        cnt_q;
   logic                 blk_q;
   logic signed [SW-1:0] blk_sum_q;

   logic                 cap;
   logic signed [12:0]   dc;
   logic signed [13:0]   diff;
   logic signed [12:0]   y;
   logic signed [DW:0]   acc_sum;
   logic signed [DW-1:0] acc_sat;
   logic signed [SW-1:0] sum_next;
   logic                 last;
   logic                 new_res;
   logic signed [12:0]   avg;
   logic [15:0]          sample_d;
   logic                 valid_d;
   logic                 ovr_set;
   logic                 ovr_d;

   // One capture per i_dv rising edge; dv_q follows i_dv even while disabled.
   assign cap = i_dv & ~dv_q & en;

   always_comb begin
      dc      = dc_acc_q[DW-1:DC_SHIFT];
      diff    = {x_q[12], x_q} - {dc[12], dc};
      acc_sum = {dc_acc_q[DW-1], dc_acc_q} + {{(DW-13){diff[13]}}, diff};
      if (acc_sum[DW] != acc_sum[DW-1]) begin
         acc_sat = {acc_sum[DW], {(DW-1){~acc_sum[DW]}}};
      end else begin
         acc_sat = acc_sum[DW-1:0];
      end
      if (i_dc_bypass) begin
         y = x_q;
      end else if (diff[13] != diff[12]) begin
         y = diff[13] ? 13'h1000 : 13'h0fff;
      end else begin
         y = diff[12:0];
      end
      sum_next = sum_q + SW'(y);
      last     = (cnt_q == CntLast);
   end

   assign new_res = blk_q & en;
   assign avg     = blk_sum_q[SW-1:AVG_LOG2];

   // A new result is dropped (and flagged) only when the held one cannot leave this edge.
   always_comb begin
      valid_d  = o_valid & ~i_ready;
      sample_d = o_sample;
      ovr_set  = 1'b0;
      if (new_res) begin
         if (!o_valid || i_ready) begin
            valid_d  = 1'b1;
            sample_d = {avg, 3'b000};
         end else begin
            ovr_set = 1'b1;
         end
      end
      ovr_d = ovr_set | (o_overrun & ~i_clr_overrun);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dv_q      <= 1'b0;
         cap_q     <= 1'b0;
         data_q    <= '0;
         s1_q      <= 1'b0;
         x_q       <= '0;
         dc_acc_q  <= '0;
         sum_q     <= '0;
         cnt_q     <= '0;
         blk_q     <= 1'b0;
         blk_sum_q <= '0;
         o_sample  <= '0;
         o_valid   <= 1'b0;
         o_overrun <= 1'b0;
      end else begin
         dv_q  <= i_dv;
         cap_q <= cap;
         if (cap) begin
            data_q <= i_data;
         end
         s1_q <= cap_q & en;
         if (cap_q) begin
            x_q <= {1'b0, data_q} - 13'd2048;
         end
         blk_q <= 1'b0;
         if (!en) begin
            sum_q <= '0;
            cnt_q <= '0;
         end else if (s1_q) begin
            if (!i_dc_bypass) begin
               dc_acc_q <= acc_sat;
            end
            if (last) begin
               blk_sum_q <= sum_next;
               blk_q     <= 1'b1;
               sum_q     <= '0;
               cnt_q     <= '0;
            end else begin
               sum_q <= sum_next;
               cnt_q <= cnt_q + CW'(1);
            end
         end
         o_valid   <= valid_d;
         o_sample  <= sample_d;
         o_overrun <= ovr_d;
      end
   end

endmodule

// File: tb/tb_adc_sample_conditioner.sv
// Bench for adc_sample_conditioner: scenario tasks compared against an arithmetic model of
// capture, DC tracking and block averaging.
module tb_adc_sample_conditioner;

   localparam int AVG_LOG2 = 2;
   localparam int DC_SHIFT = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [11:0] i_data = '0;
   logic        i_dv = 1'b0;
   logic        i_dc_bypass = 1'b1;
   logic        i_ready = 1'b1;
   logic        i_clr_overrun = 1'b0;
   logic [15:0] o_sample;
   logic        o_valid;
   logic        o_overrun;

   int total = 0;
   int bad = 0;
   int xfers = 0;

   longint      m_dc_acc = 0;
   longint      m_blk[$];
   logic [15:0] m_exp[$];
   logic [15:0] got[$];

   logic [11:0] pat [0:15] = '{12'h800, 12'h800, 12'h800, 12'h800,
                               12'hfff, 12'hfff, 12'hfff, 12'hfff,
                               12'h000, 12'h000, 12'h000, 12'h000,
                               12'h800, 12'h801, 12'h801, 12'h801};
   logic [15:0] lit [0:3] = '{16'h0000, 16'h3ff8, 16'hc000, 16'h0000};

   always #5 clk = ~clk;

   adc_sample_conditioner #(
      .AVG_LOG2(AVG_LOG2),
      .DC_SHIFT(DC_SHIFT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .i_data       (i_data),
      .i_dv         (i_dv),
      .i_dc_bypass  (i_dc_bypass),
      .i_ready      (i_ready),
      .i_clr_overrun(i_clr_overrun),
      .o_sample     (o_sample),
      .o_valid      (o_valid),
      .o_overrun    (o_overrun)
   );

   // Records every transfer (valid and ready both high ahead of the next rising edge).
   always @(negedge clk) begin
      if (rst_n && o_valid && i_ready) begin
         got.push_back(o_sample);
         xfers++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic longint floor_div(input longint a, input longint b);
      if (a >= 0) return a / b;
      return -((-a + b - 1) / b);
   endfunction

   function automatic longint clamp(input longint v, input longint lo, input longint hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   function automatic void model_sample(input logic [11:0] d, input logic byp);
      longint x, dc, diff, y, s, lim;
      lim  = longint'(1) << (12 + DC_SHIFT);
      x    = longint'(d) - 2048;
      dc   = floor_div(m_dc_acc, longint'(1) << DC_SHIFT);
      diff = x - dc;
      if (byp) begin
         y = x;
      end else begin
         y        = clamp(diff, -4096, 4095);
         m_dc_acc = clamp(m_dc_acc + diff, -lim, lim - 1);
      end
      m_blk.push_back(y);
      if (m_blk.size() == (1 << AVG_LOG2)) begin
         s = 0;
         foreach (m_blk[i]) s += m_blk[i];
         m_exp.push_back(16'(floor_div(s, longint'(1) << AVG_LOG2) * 8));
         m_blk.delete();
      end
   endfunction

   task automatic model_reset();
      m_dc_acc = 0;
      m_blk.delete();
      m_exp.delete();
   endtask

   // Called one step after a rising edge; returns one step after the edge that runs stage 2.
   task automatic send(input logic [11:0] d);
      i_data = d;
      i_dv   = 1'b1;
      model_sample(d, i_dc_bypass);
      @(posedge clk); #1;
      i_dv = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
   endtask

   task automatic flush();
      en = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      en = 1'b1;
      m_blk.delete();
   endtask

   task automatic test_reset();
      int x0;
      repeat (3) begin @(posedge clk); #1; end
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL por_valid: got %b want 0", o_valid); end
      total++; if (o_sample !== 16'h0) begin bad++; $display("FAIL por_sample: got %h want 0000", o_sample); end
      rst_n = 1'b1; en = 1'b1; i_ready = 1'b0; i_dc_bypass = 1'b1;
      model_reset();
      for (int i = 0; i < 8; i++) send(12'($urandom));
      @(posedge clk); #1;
      total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_valid: got %b want 1", o_valid); end
      total++; if (o_overrun !== 1'b1) begin bad++; $display("FAIL pre_reset_ovr: got %b want 1", o_overrun); end
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL async_valid: got %b want 0", o_valid); end
      total++; if (o_sample !== 16'h0) begin bad++; $display("FAIL async_sample: got %h want 0000", o_sample); end
      total++; if (o_overrun !== 1'b0) begin bad++; $display("FAIL async_ovr: got %b want 0", o_overrun); end
      @(posedge clk); #1;
      rst_n = 1'b1; i_ready = 1'b1;
      model_reset();
      x0 = xfers;
      for (int i = 0; i < 3; i++) send(12'($urandom));
      @(negedge clk);
      total++; if (xfers - x0 !== 0) begin bad++; $display("FAIL first3_valid: got %0d results want 0", xfers - x0); end
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL first3_ovalid: got %b want 0", o_valid); end
      @(posedge clk); #1;
      flush();
   endtask

   task automatic test_basic();
      i_dc_bypass = 1'b1; i_ready = 1'b1;
      for (int g = 0; g < 4; g++) begin
         got.delete(); m_exp.delete();
         for (int k = 0; k < 4; k++) send(pat[g*4+k]);
         @(negedge clk);
         total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL lat_early[%0d]: got %b want 0", g, o_valid); end
         @(negedge clk);
         total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL lat_valid[%0d]: got %b want 1", g, o_valid); end
         total++; if (o_sample !== m_exp[0]) begin bad++; $display("FAIL basic_model[%0d]: got %h want %h", g, o_sample, m_exp[0]); end
         total++; if (o_sample !== lit[g]) begin bad++; $display("FAIL basic_const[%0d]: got %h want %h", g, o_sample, lit[g]); end
         @(negedge clk);
         total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL pulse_width[%0d]: got %b want 0", g, o_valid); end
         @(posedge clk); #1;
      end
      m_exp.delete(); got.delete();
   endtask

   task automatic test_dv_width();
      int x0;
      i_ready = 1'b1; got.delete(); m_exp.delete();
      x0 = xfers;
      for (int n = 0; n < 8; n++) begin
         i_data = 12'($urandom);
         i_dv   = 1'b1;
         model_sample(i_data, i_dc_bypass);
         repeat (155) begin @(posedge clk); #1; end
         i_dv = 1'b0;
         repeat (2345) begin @(posedge clk); #1; end
      end
      total++; if (xfers - x0 !== 2) begin bad++; $display("FAIL dv_count: got %0d results want 2", xfers - x0); end
      total++; if (got.size() !== m_exp.size()) begin bad++; $display("FAIL dv_size: got %0d want %0d", got.size(), m_exp.size()); end
      for (int i = 0; i < got.size() && i < m_exp.size(); i++) begin
         total++; if (got[i] !== m_exp[i]) begin bad++; $display("FAIL dv_data[%0d]: got %h want %h", i, got[i], m_exp[i]); end
      end
      m_exp.delete(); got.delete();
   endtask

   task automatic test_overrun();
      i_ready = 1'b0; got.delete(); m_exp.delete();
      for (int i = 0; i < 8; i++) send(12'($urandom));
      repeat (2) begin @(posedge clk); #1; end
      total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL ovr_held_valid: got %b want 1", o_valid); end
      total++; if (o_sample !== m_exp[0]) begin bad++; $display("FAIL ovr_held_data: got %h want %h", o_sample, m_exp[0]); end
      total++; if (o_overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag: got %b want 1", o_overrun); end
      i_ready = 1'b1;
      @(posedge clk); #1;
      i_ready = 1'b0;
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL ovr_drain: got %b want 0", o_valid); end
      total++; if (o_overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky: got %b want 1", o_overrun); end
      total++; if (got.size() !== 1) begin bad++; $display("FAIL ovr_xfer_cnt: got %0d want 1", got.size()); end
      if (got.size() > 0) begin
         total++; if (got[0] !== m_exp[0]) begin bad++; $display("FAIL ovr_xfer_data: got %h want %h", got[0], m_exp[0]); end
      end
      i_clr_overrun = 1'b1;
      @(posedge clk); #1;
      i_clr_overrun = 1'b0;
      total++; if (o_overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear: got %b want 0", o_overrun); end
      i_ready = 1'b1; m_exp.delete(); got.delete();
   endtask

   task automatic test_dc_track();
      logic signed [15:0] v;
      i_dc_bypass = 1'b0; i_ready = 1'b1; got.delete(); m_exp.delete();
      for (int i = 0; i < 8192; i++) send(12'ha00);
      repeat (2) begin @(posedge clk); #1; end
      total++; if (got.size() !== m_exp.size()) begin bad++; $display("FAIL dc_size: got %0d want %0d", got.size(), m_exp.size()); end
      for (int i = 0; i < got.size() && i < m_exp.size(); i++) begin
         total++; if (got[i] !== m_exp[i]) begin bad++; $display("FAIL dc_data[%0d]: got %h want %h", i, got[i], m_exp[i]); end
      end
      if (got.size() > 0) begin
         v = $signed(got[0]);
         total++; if (v < 16'sh0fe0 || v > 16'sh1000) begin bad++; $display("FAIL dc_first: got %h want near 1000", got[0]); end
         v = $signed(got[got.size()-1]);
         total++; if (v > 16 || v < -16) begin bad++; $display("FAIL dc_settled: got %h want |x|<=16", got[got.size()-1]); end
      end
      i_dc_bypass = 1'b1; got.delete(); m_exp.delete();
      for (int i = 0; i < 8; i++) send(12'ha00);
      repeat (2) begin @(posedge clk); #1; end
      total++; if (got.size() !== 2) begin bad++; $display("FAIL dc_byp_cnt: got %0d want 2", got.size()); end
      for (int i = 0; i < got.size() && i < m_exp.size(); i++) begin
         total++; if (got[i] !== 16'h1000) begin bad++; $display("FAIL dc_bypass[%0d]: got %h want 1000", i, got[i]); end
         total++; if (got[i] !== m_exp[i]) begin bad++; $display("FAIL dc_byp_model[%0d]: got %h want %h", i, got[i], m_exp[i]); end
      end
      m_exp.delete(); got.delete();
   endtask

   task automatic test_interrupt();
      int x0;
      i_dc_bypass = 1'b1; got.delete(); m_exp.delete();
      x0 = xfers;
      for (int i = 0; i < 2; i++) send(12'($urandom));
      en = 1'b0;
      m_blk.delete();
      repeat (10) begin @(posedge clk); #1; end
      en = 1'b1;
      for (int i = 0; i < 4; i++) send(12'($urandom));
      repeat (3) begin @(posedge clk); #1; end
      total++; if (xfers - x0 !== 1) begin bad++; $display("FAIL en_count: got %0d want 1", xfers - x0); end
      if (got.size() > 0 && m_exp.size() > 0) begin
         total++; if (got[0] !== m_exp[0]) begin bad++; $display("FAIL en_data: got %h want %h", got[0], m_exp[0]); end
      end
      i_dc_bypass = 1'b0; got.delete(); m_exp.delete();
      x0 = xfers;
      for (int i = 0; i < 2; i++) send(12'ha00);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      model_reset();
      for (int i = 0; i < 4; i++) send(12'ha00);
      repeat (3) begin @(posedge clk); #1; end
      total++; if (xfers - x0 !== 1) begin bad++; $display("FAIL rst_count: got %0d want 1", xfers - x0); end
      if (got.size() > 0 && m_exp.size() > 0) begin
         total++; if (got[0] !== m_exp[0]) begin bad++; $display("FAIL rst_model: got %h want %h", got[0], m_exp[0]); end
         total++; if (got[0] !== 16'h0ff8) begin bad++; $display("FAIL rst_dc_restart: got %h want 0ff8", got[0]); end
      end
      m_exp.delete(); got.delete();
   endtask

   task automatic test_random();
      i_ready = 1'b1; got.delete(); m_exp.delete();
      for (int i = 0; i < 32; i++) begin
         i_dc_bypass = 1'($urandom);
         send(12'($urandom));
         repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
      repeat (3) begin @(posedge clk); #1; end
      total++; if (got.size() !== m_exp.size()) begin bad++; $display("FAIL rnd_size: got %0d want %0d", got.size(), m_exp.size()); end
      for (int i = 0; i < got.size() && i < m_exp.size(); i++) begin
         total++; if (got[i] !== m_exp[i]) begin bad++; $display("FAIL rnd_data[%0d]: got %h want %h", i, got[i], m_exp[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_dv_width();
      test_overrun();
      test_dc_track();
      test_interrupt();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
